serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial addition controller that drives the team's gate-level 1-bit full-adder cell over WIDTH clock cycles.
- Loads two WIDTH-bit operands and a carry-in.
- Each cycle, presents one bit pair plus the stored carry to the external full adder.
- Captures the cell's sum and carry-out back into registers.
- Sits directly upstream and downstream of the 1-bit adder: it feeds the cell's a/b/ci inputs and consumes its s/co outputs.

Parameters:
WIDTH, 8, operand/result width in bits (≥2); also the number of SHIFT cycles.

Ports:
clk  input  1  rising-edge clock; period ≥ 25 ns (full-adder worst path 20 ns); benches use 40 ns.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled at a rising edge in IDLE or DONE.
a_in  input  WIDTH  operand A, captured when start is accepted.
b_in  input  WIDTH  operand B, captured when start is accepted.
cin  input  1  carry-in, captured when start is accepted.
fa_a  output  1  to full-adder a.
fa_b  output  1  to full-adder b.
fa_ci  output  1  to full-adder ci.
fa_s  input  1  from full-adder s.
fa_co  input  1  from full-adder co.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse when the result becomes valid.
sum  output  WIDTH  result; held stable from done until the next accepted start.
cout  output  1  final carry-out; held stable with sum.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; clk and rst are the only clock/reset ports.
- Reset values: state=IDLE; busy=0; done=0; sum=0; cout=0; internal a_sh, b_sh, carry and bit counter all 0.
- fa_a/fa_b/fa_ci are 0 whenever the state is not SHIFT.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load a_sh=a_in, b_sh=b_in, carry=cin, cnt=0; go to SHIFT.
  - start=0 → stay.
- SHIFT:
  - Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_ci=carry.
  - Each edge:
    - sum shifts right with fa_s entering at MSB;
    - carry<=fa_co;
    - a_sh and b_sh shift right (0 fill);
    - cnt increments.
  - The edge on which cnt==WIDTH-1 performs the last capture and goes to DONE.
  - busy=1 for exactly WIDTH cycles.
- DONE:
  - done=1 for exactly one cycle; cout=carry.
  - The bit arithmetic completes on the last SHIFT edge, so sum and cout are valid while done is high.
  - start=1 → reload and go to SHIFT (back-to-back operation); otherwise go to IDLE.
  - sum and cout are held until the next load.
  - On a new load, sum is cleared only through shifting; sum is not valid during SHIFT.
- Latency: start edge → done high after WIDTH+1 edges.
- Input rules:
  - start while busy is ignored; operands are not recaptured.
  - a_in, b_in and cin are don't-care except on the accepting edge.
- Reset mid-operation: rst=1 on any edge wins over all other conditions and returns everything to reset values. An in-flight operation is abandoned and done never pulses.
- Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1).

Optional Feature:
Macro SERIAL_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1 → b_sh loads ~b_in and carry loads 1, ignoring cin, giving {cout,sum} = a_in + ~b_in + 1.
  - cout=1 means no borrow.
  - sub=0 → normal add.
- When undefined:
  - No sub port; add only.

Test Plan:
1. a_in=8'h0F, b_in=8'h01, cin=0, start pulse:
   - busy high 8 cycles; done pulses on cycle 9;
   - sum=8'h10, cout=0.
2. a_in=8'hFF, b_in=8'h01, cin=0:
   - sum=8'h00, cout=1;
   - fa_ci observed 1 on SHIFT cycles 2–8.
3. a_in=8'hA5, b_in=8'h5A, cin=1:
   - sum=8'h00, cout=1.
   - Then start held high in DONE with a_in=8'h03, b_in=8'h04, cin=0: immediate reload, next result sum=8'h07, cout=0.
4. During SHIFT of case 1, start=1 with a_in=8'hFF, b_in=8'hFF:
   - ignored; result still 8'h10.
   - fa_a/fa_b/fa_ci=0 in IDLE.
5. rst=1 at SHIFT cycle 4:
   - next edge: busy=0, sum=0, cout=0, state IDLE;
   - no done pulse.
6. With SERIAL_SUB_EN: a_in=8'h05, b_in=8'h07, sub=1:
   - sum=8'hFE, cout=0.
   - With a_in=8'h07, b_in=8'h05, sub=1: sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add controller driving an external 1-bit full-adder cell.
// Operands are loaded on an accepted start, then one bit pair per cycle is presented
// LSB first on fa_a/fa_b/fa_ci. The cell's fa_s/fa_co are captured back every cycle.
// After WIDTH shift cycles the result is on sum/cout and done pulses for one cycle.
// Optional macro SERIAL_SUB_EN adds a 'sub' input selecting a - b (two's complement).
//
// Handshake: start is a request sampled at a rising edge only in IDLE or DONE; while
// busy is high start is ignored. done is a one-cycle valid strobe for sum/cout, which
// stay stable until the next accepted start.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               load;
    logic               last_bit;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    // Start is honoured only when no operation is in flight.
    assign load     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Operand B and initial carry as loaded; subtraction inverts B and forces carry-in.
`ifdef SERIAL_SUB_EN
    always_comb begin
        b_load     = sub ? ~b_in : b_in;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load     = b_in;
        carry_load = cin;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH cycles, DONE for one.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode: full-adder drive is gated to zero outside SHIFT.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        fa_a  = 1'b0;
        fa_b  = 1'b0;
        fa_ci = 1'b0;
        case (state)
            ST_SHIFT: begin
                busy  = 1'b1;
                fa_a  = a_sh[0];
                fa_b  = b_sh[0];
                fa_ci = carry;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: load operands, then shift one bit per cycle through the external cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (load) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == ST_SHIFT) begin
            sum_r <= {fa_s, sum_r[WIDTH-1:1]};
            carry <= fa_co;
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
            // Final carry-out is committed together with the last sum bit.
            if (last_bit) begin
                cout_r <= fa_co;
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule
